// File: rtl/byte_stream_fifo_pkg.sv
// Shared definitions for the byte stream FIFO: default depth and the
// pointer-width helper used throughout the application.
package byte_stream_fifo_pkg;

  localparam int BYTE_FIFO_DEPTH = 16;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/byte_stream_fifo.sv
// First-word-fall-through byte FIFO with valid/ready on both sides, placed
// between the CDC OUT endpoint and the application consumer.
module byte_stream_fifo
  import byte_stream_fifo_pkg::*;
#(
  parameter int DEPTH = BYTE_FIFO_DEPTH,
  parameter int AW    = ceil_log2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [7:0]    in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [7:0]    out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW:0]   level_o
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        full;
  logic        empty;
  logic        wr_fire;
  logic        rd_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    empty       = (wr_q == rd_q);
    full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    in_ready_o  = !full && !rst_i && !flush_i;
    out_valid_o = !empty;
    wr_fire     = in_valid_i && in_ready_o;
    rd_fire     = out_valid_o && out_ready_i;
    wr_d        = wr_q;
    rd_d        = rd_q;
    if (flush_i) begin
      rd_d = wr_q;
    end else begin
      if (wr_fire) wr_d = wr_q + 1'b1;
      if (rd_fire) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: the storage array has no reset; out_valid_o masks stale contents,
  // and leaving it unreset lets it map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wr_q[AW-1:0]] <= in_data_i;
    end
  end

  // Combinational read keeps fall-through timing: the head byte is visible
  // the cycle after it is written.
  assign out_data_o = mem_q[rd_q[AW-1:0]];
  assign level_o    = wr_q - rd_q;

endmodule

// File: tb/tb_byte_stream_fifo.sv
// Self-checking bench for byte_stream_fifo: directed scenarios plus a
// randomized stream, all checked against a queue-based reference model.
module tb_byte_stream_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;

  // Reference model: the stored bytes, oldest first.
  byte unsigned model[$];

  byte_stream_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .level_o    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and apply the FIFO rules to the model.
  task automatic tick();
    bit wf, rf;
    wf = in_valid && !rst && !flush && (model.size() < DEPTH);
    rf = out_ready && (model.size() > 0);
    @(posedge clk);
    #1;
    if (rst || flush) begin
      model.delete();
    end else begin
      if (rf) void'(model.pop_front());
      if (wf) model.push_back(in_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL release_empty: got valid=%b level=%0d want 0/0", out_valid, level);
    end
    tick();
  endtask

  task automatic test_single();
    in_data = 8'hA5; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got valid=%b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 5'd1) begin
      errors++;
      $display("FAIL single_write: got valid=%b data=%h level=%0d want 1/a5/1", out_valid, out_data, level);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL single_read: got valid=%b level=%0d want 0/0", out_valid, level);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      tick();
    end
    checks++;
    if (in_ready !== 1'b0 || level !== 5'd16) begin
      errors++; $display("FAIL fill_full: got ready=%b level=%0d want 0/16", in_ready, level);
    end
    in_data = 8'hFF;
    tick(); tick();
    in_valid = 1'b0;
    checks++;
    if (level !== 5'(model.size()) || level !== 5'd16) begin
      errors++; $display("FAIL fill_holdoff: got level=%0d want 16", level);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        errors++; $display("FAIL drain_order[%0d]: got valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL drain_empty: got valid=%b level=%0d want 0/0", out_valid, level);
    end
  endtask

  task automatic test_full_rw();
    byte unsigned exp;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'($urandom); in_valid = 1'b1;
      tick();
    end
    in_data = 8'h5C; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_rw_ready: got %b want 0", in_ready); end
    tick();
    out_ready = 1'b0;
    checks++;
    if (level !== 5'd15 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_rw_read_only: got level=%0d ready=%b want 15/1", level, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (level !== 5'd16) begin errors++; $display("FAIL full_rw_accept: got level=%0d want 16", level); end
    out_ready = 1'b1;
    while (model.size() > 0) begin
      exp = model[0];
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL full_rw_drain: got valid=%b data=%h want 1/%h", out_valid, out_data, exp);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_rw_tail: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rcvd = 0;
    int cycles = 0;
    while (rcvd < 40 && cycles < 2000) begin
      in_valid  = (sent < 40) && ($urandom_range(0, 3) != 0);
      in_data   = 8'(sent);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (in_ready !== (model.size() < DEPTH) || level !== 5'(model.size()) || level > 5'd16) begin
        errors++;
        $display("FAIL wrap_state: got ready=%b level=%0d want %b/%0d", in_ready, level,
                 model.size() < DEPTH, model.size());
      end
      if (model.size() > 0 && out_ready) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'(rcvd)) begin
          errors++; $display("FAIL wrap_data: got valid=%b data=%h want 1/%h", out_valid, out_data, 8'(rcvd));
        end
        rcvd++;
      end
      if (in_valid && model.size() < DEPTH) sent++;
      tick();
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (rcvd != 40 || out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_complete: got %0d bytes valid=%b want 40/0", rcvd, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom_range(0, 8'hDF)); in_valid = 1'b1;
      tick();
    end
    checks++;
    if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level: got %0d want 5", level); end
    flush = 1'b1; in_data = 8'hEE; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty: got level=%0d valid=%b want 0/0", level, out_valid);
    end
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++; $display("FAIL flush_first: got valid=%b data=%h want 1/11", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      errors++; $display("FAIL flush_second: got valid=%b data=%h want 1/22", out_valid, out_data);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL flush_tail: got valid=%b level=%0d want 0/0", out_valid, level);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_data = 8'h70 + 8'(i); in_valid = 1'b1;
      tick();
    end
    checks++;
    if (level !== 5'd7) begin errors++; $display("FAIL rst_mid_pre_level: got %0d want 7", level); end
    rst = 1'b1; in_data = 8'h99;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL rst_mid_during: got ready=%b level=%0d want 0/0", in_ready, level);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_after[%0d]: got valid=%b level=%0d ready=%b want 0/0/1", i, out_valid, level, in_ready);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    test_reset();
    test_single();
    test_fill();
    test_full_rw();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_stream_fifo.md
# byte_stream_fifo

Synchronous first-word-fall-through byte FIFO with valid/ready on both sides. It sits between the USB_CDC OUT endpoint (out_data/out_valid/out_ready) and the application consumer. It absorbs bursts while the application is stalled, for example while it is in a programmed wait or sourcing CRC bytes. It also reports its fill level so the application can throttle commands.

## Interface
Parameters:
- DEPTH, 16: number of byte entries. Must be a power of 2, range 2..1024.
- AW, ceil_log2(DEPTH): pointer width. Derived; must not be overridden.

Ports:
- clk_i, input, 1: single clock. All logic is on its rising edge.
- rst_i, input, 1: reset. Synchronous, active-high.
- flush_i, input, 1: synchronous discard of all stored bytes.
- in_data_i, input, 8: write data. Valid while in_valid_i is high.
- in_valid_i, input, 1: write request. Data and valid are held until consumed.
- in_ready_o, output, 1: FIFO can accept a byte. A byte is written on a cycle where in_valid_i and in_ready_o are both high.
- out_data_o, output, 8: oldest stored byte. Valid while out_valid_o is high.
- out_valid_o, output, 1: FIFO is non-empty.
- out_ready_i, input, 1: consumer takes out_data_o on a cycle where out_valid_o and out_ready_i are both high.
- level_o, output, AW+1: number of stored bytes, 0..DEPTH.

## Operation
- Storage: DEPTH x 8 register array. Write pointer wr_q and read pointer rd_q, each AW+1 bits; the MSB is the wrap bit.
- Empty when wr_q == rd_q. Full when the pointers differ only in the MSB.
- Outputs:
  - in_ready_o = !full && !rst_i && !flush_i
  - out_valid_o = !empty
  - out_data_o = mem[rd_q[AW-1:0]], combinational read.
  - level_o = wr_q - rd_q, modulo 2^(AW+1).
- Write fire (in_valid_i && in_ready_o): mem[wr_q] <= in_data_i; wr_q increments.
- Read fire (out_valid_o && out_ready_i): rd_q increments.
- Pointers wrap naturally at 2^(AW+1). There is no explicit wrap logic.
- Simultaneous read and write when neither full nor empty: both occur; level is unchanged.
- Full: in_ready_o is low, so no write is accepted that cycle, even if a read fires in the same cycle. No pass-through. in_ready_o rises the cycle after the read.
- Empty: out_valid_o is low, so a write is not visible on the output in the same cycle. No bypass path.
- The consumer must not be presented with data that is modified while valid. out_data_o changes only on a read fire or on an empty-to-non-empty transition.
- flush_i has priority over both fires:
  - rd_q <= wr_q; any write presented in that cycle is dropped.
  - Stored bytes are lost; level_o reads 0 on the next cycle.
- rst_i has priority over flush_i:
  - wr_q and rd_q are set to 0.
  - The memory array is not cleared.

## Timing
- Output values while rst_i is high and on the first cycle after release:
  - in_ready_o = 0 during reset, then 1.
  - out_valid_o = 0.
  - level_o = 0.
  - out_data_o is don't-care while out_valid_o is 0.
- Write-to-read latency: a byte written at edge N gives out_valid_o high in the cycle after edge N. Minimum one cycle through the FIFO.
- Sustained throughput: one byte per cycle on each side, at any level from 1 to DEPTH-1.
- Reset or flush asserted mid-stream:
  - The next cycle is empty and ready.
  - Bytes written in the flush cycle are not stored.
- Per clock, in_ready_o depends only on registered state and rst_i/flush_i. It has no combinational path from out_ready_i.

## Structure
- Shared package:
  - ceil_log2 function, the same algorithm the application already uses.
  - localparam for the default depth (BYTE_FIFO_DEPTH = 16).
- Single flat module. No sub-module: pointers, flags and the array fit in one always block plus one combinational block.
- The array may infer distributed RAM or registers. A registered-read block RAM is not allowed, because it would break fall-through timing.

## Test plan
- Reset release, then write 0xA5 with out_ready_i = 0:
  - One cycle later out_valid_o = 1, out_data_o = 0xA5, level_o = 1.
  - Asserting out_ready_i for one cycle gives level_o = 0 and out_valid_o = 0.
- Fill to DEPTH=16 with 0x01..0x10 while out_ready_i = 0:
  - After 16 writes, in_ready_o = 0 and level_o = 16.
  - A 17th byte 0xFF is held off, not stored.
  - Drain gives 0x01..0x10 in order.
- Full, with a read and a write presented in the same cycle:
  - Only the read fires; level_o goes 16 to 15.
  - On the next cycle in_ready_o = 1 and the held byte is accepted.
- Wrap: stream 40 bytes 0x00..0x27 with random stalls on both sides.
  - Output sequence is exact, with no loss or duplication.
  - level_o always stays in 0..16.
- Flush with level_o = 5 and in_valid_i high in the same cycle:
  - Next cycle level_o = 0 and out_valid_o = 0; the flush-cycle byte is absent.
  - The following writes come out first.
- rst_i asserted mid-burst at level_o = 7:
  - in_ready_o = 0 during reset; after release level_o = 0.
  - Stale data never appears with out_valid_o = 1.
